id_hazard_sequencer: RTL and testbench

ID_HAZARD_SEQUENCER -- requirements
Module: id_hazard_sequencer

---
 rtl/id_hazard_sequencer.sv | 147 ++++++++++++++
 tb/tb_id_hazard_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_sequencer
// Description : ID-stage hazard sequencer: load-use stall, jump redirect and
//               branch wait-for-resolution with timeout and stall statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_sequencer (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_is_branch,
    input  logic        id_is_jump,
    input  logic [4:0]  exe_rd,
    input  logic        exe_wreg,
    input  logic        exe_m2reg,
    input  logic        mem_br_valid,
    input  logic        mem_br_taken,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  pc_sel,
    output logic [15:0] stall_cnt,
    output logic        br_timeout
);

    localparam logic [1:0]  c_sel_pc4   = 2'd0;
    localparam logic [1:0]  c_sel_bpc   = 2'd1;
    localparam logic [1:0]  c_sel_jpc   = 2'd2;
    localparam logic [1:0]  c_wcnt_last = 2'd3;
    localparam logic [15:0] c_stall_max = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_wcnt;
    logic [1:0]  w_wcnt_nxt;
    logic [15:0] r_stall_cnt;
    logic        r_br_timeout;
    logic        w_timeout_set;
    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_lu;

    // A load in EX feeding an ID source; r0 is never a real dependency.
    assign w_rs_hit = id_use_rs && (id_rs == exe_rd);
    assign w_rt_hit = id_use_rt && (id_rt == exe_rd);
    assign w_lu     = exe_m2reg && exe_wreg && (exe_rd != 5'd0) && (w_rs_hit || w_rt_hit);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_RUN;
            r_wcnt       <= 2'd0;
            r_stall_cnt  <= 16'd0;
            r_br_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (!pc_we && (r_stall_cnt != c_stall_max)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_timeout_set) begin
                r_br_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        pc_we         = 1'b0;
        ifid_we       = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pc_sel        = c_sel_pc4;
        w_state_nxt   = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_timeout_set = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                w_wcnt_nxt = 2'd0;
                if (w_lu) begin
                    idex_bubble = 1'b1;
                end else if (id_is_branch) begin
                    // Hold PC and keep feeding nops until MEM resolves the branch.
                    ifid_we     = 1'b1;
                    ifid_flush  = 1'b1;
                    w_state_nxt = ST_BR_WAIT;
                end else if (id_is_jump) begin
                    pc_we      = 1'b1;
                    pc_sel     = c_sel_jpc;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
            end
            ST_BR_WAIT: begin
                if (mem_br_valid && mem_br_taken) begin
                    pc_we       = 1'b1;
                    pc_sel      = c_sel_bpc;
                    ifid_we     = 1'b1;
                    ifid_flush  = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_wcnt_nxt  = 2'd0;
                end else if (mem_br_valid || (r_wcnt == c_wcnt_last)) begin
                    // Not taken, or gave up waiting: fall through sequentially.
                    pc_we         = 1'b1;
                    ifid_we       = 1'b1;
                    w_state_nxt   = ST_RUN;
                    w_wcnt_nxt    = 2'd0;
                    w_timeout_set = !mem_br_valid;
                end else begin
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                    w_wcnt_nxt = r_wcnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wcnt_nxt  = 2'd0;
            end
        endcase

        // Pipeline is frozen and filled with nops while reset is held.
        if (!clrn) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pc_sel      = c_sel_pc4;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign br_timeout = r_br_timeout;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_hazard_sequencer
// Description : Scoreboard bench for id_hazard_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_hazard_sequencer;

    logic        clk;
    logic        clrn;
    logic [4:0]  id_rs, id_rt, exe_rd;
    logic        id_use_rs, id_use_rt, id_is_branch, id_is_jump;
    logic        exe_wreg, exe_m2reg, mem_br_valid, mem_br_taken;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [1:0]  pc_sel;
    logic [15:0] stall_cnt;
    logic        br_timeout;

    id_hazard_sequencer u_dut (
        .clk          (clk),
        .clrn         (clrn),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .id_is_jump   (id_is_jump),
        .exe_rd       (exe_rd),
        .exe_wreg     (exe_wreg),
        .exe_m2reg    (exe_m2reg),
        .mem_br_valid (mem_br_valid),
        .mem_br_taken (mem_br_taken),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .pc_sel       (pc_sel),
        .stall_cnt    (stall_cnt),
        .br_timeout   (br_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_we, ifid_we, ifid_flush, idex_bubble, pc_sel}
    localparam logic [5:0] c_ctl_normal = 6'b110000;
    localparam logic [5:0] c_ctl_lu     = 6'b000100;
    localparam logic [5:0] c_ctl_brwait = 6'b011000;
    localparam logic [5:0] c_ctl_jump   = 6'b111010;
    localparam logic [5:0] c_ctl_taken  = 6'b111001;
    localparam logic [5:0] c_ctl_reset  = 6'b001100;

    typedef struct {
        string       tag;
        logic [5:0]  ctl;
        logic [15:0] stall;
        logic        to;
    } exp_t;

    exp_t        r_sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    logic        m_br;
    int          m_wcnt;
    logic [15:0] m_stall;
    logic        m_to;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_in();
        id_rs = 5'd0; id_rt = 5'd0; exe_rd = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_is_branch = 1'b0; id_is_jump = 1'b0;
        exe_wreg = 1'b0; exe_m2reg = 1'b0;
        mem_br_valid = 1'b0; mem_br_taken = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        exe_m2reg = 1'b1; exe_wreg = 1'b1; exe_rd = rd;
    endtask

    task automatic model_reset();
        m_br = 1'b0; m_wcnt = 0; m_stall = 16'd0; m_to = 1'b0;
    endtask

    // Called with inputs already driven after a falling edge: predict, push,
    // compare the DUT's response, then advance the model for the next rising edge.
    task automatic run_cycle(input string tag);
        exp_t        e;
        exp_t        got;
        logic        lu;
        logic [5:0]  ctl;
        logic        nb;
        int          nw;
        logic        nto;
        lu  = exe_m2reg && exe_wreg && (exe_rd != 5'd0) &&
              ((id_use_rs && (id_rs == exe_rd)) || (id_use_rt && (id_rt == exe_rd)));
        nb  = m_br;
        nw  = m_wcnt;
        nto = m_to;
        if (!m_br) begin
            nw = 0;
            if (lu)                ctl = c_ctl_lu;
            else if (id_is_branch) begin ctl = c_ctl_brwait; nb = 1'b1; end
            else if (id_is_jump)   ctl = c_ctl_jump;
            else                   ctl = c_ctl_normal;
        end else if (mem_br_valid && mem_br_taken) begin
            ctl = c_ctl_taken; nb = 1'b0; nw = 0;
        end else if (mem_br_valid) begin
            ctl = c_ctl_normal; nb = 1'b0; nw = 0;
        end else if (m_wcnt == 3) begin
            ctl = c_ctl_normal; nb = 1'b0; nw = 0; nto = 1'b1;
        end else begin
            ctl = c_ctl_brwait; nw = m_wcnt + 1;
        end
        e.tag = tag; e.ctl = ctl; e.stall = m_stall; e.to = m_to;
        r_sb.push_back(e);

        #1;
        got = r_sb.pop_front();
        check_eq({got.tag, ".ctl"}, {26'd0, pc_we, ifid_we, ifid_flush, idex_bubble, pc_sel}, {26'd0, got.ctl});
        check_eq({got.tag, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, got.stall});
        check_eq({got.tag, ".br_timeout"}, {31'd0, br_timeout}, {31'd0, got.to});

        if (!ctl[5] && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
        m_br = nb; m_wcnt = nw; m_to = nto;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, ".ctl"}, {26'd0, pc_we, ifid_we, ifid_flush, idex_bubble, pc_sel}, {26'd0, c_ctl_reset});
        check_eq({tag, ".stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
        check_eq({tag, ".br_timeout"}, {31'd0, br_timeout}, 32'd0);
    endtask

    initial begin
        clrn = 1'b0;
        clear_in();
        model_reset();
        @(negedge clk);
        #1 check_reset("reset_hold");
        @(negedge clk);
        clrn = 1'b1;

        clear_in(); run_cycle("idle0");
        @(negedge clk); clear_in(); run_cycle("idle1");

        // Load-use on rs, then r0 destination and non-matching forms
        @(negedge clk); clear_in(); set_load(5'd5); id_rs = 5'd5; id_use_rs = 1'b1; run_cycle("lu_rs");
        @(negedge clk); clear_in(); set_load(5'd0); id_rs = 5'd0; id_use_rs = 1'b1; run_cycle("lu_rd0");
        @(negedge clk); clear_in(); set_load(5'd9); id_rt = 5'd9; id_use_rt = 1'b1; run_cycle("lu_rt");
        @(negedge clk); clear_in(); set_load(5'd9); id_rt = 5'd9; id_use_rt = 1'b0; run_cycle("lu_rt_unused");
        @(negedge clk); clear_in(); set_load(5'd7); exe_m2reg = 1'b0; id_rs = 5'd7; id_use_rs = 1'b1; run_cycle("alu_dep");
        @(negedge clk); clear_in(); id_is_jump = 1'b1; run_cycle("jump");
        @(negedge clk); clear_in(); mem_br_valid = 1'b1; mem_br_taken = 1'b1; run_cycle("run_ignores_valid");

        // Taken branch; ID noise during the wait must be ignored
        @(negedge clk); clear_in(); id_is_branch = 1'b1; run_cycle("tk_issue");
        @(negedge clk); clear_in(); set_load(5'd3); id_rs = 5'd3; id_use_rs = 1'b1; id_is_jump = 1'b1; run_cycle("tk_wait0");
        @(negedge clk); clear_in(); mem_br_valid = 1'b1; mem_br_taken = 1'b1; run_cycle("tk_resolve");
        @(negedge clk); clear_in(); run_cycle("tk_after");

        // Not-taken branch
        @(negedge clk); clear_in(); id_is_branch = 1'b1; run_cycle("nt_issue");
        @(negedge clk); clear_in(); run_cycle("nt_wait0");
        @(negedge clk); clear_in(); mem_br_valid = 1'b1; run_cycle("nt_resolve");
        @(negedge clk); clear_in(); run_cycle("nt_after");

        // Timeout: four wait cycles, then sticky flag
        @(negedge clk); clear_in(); id_is_branch = 1'b1; run_cycle("to_issue");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clear_in(); id_is_branch = 1'b1; run_cycle($sformatf("to_wait%0d", i));
        end
        @(negedge clk); clear_in(); run_cycle("to_after");
        @(negedge clk); clear_in(); run_cycle("to_sticky");

        // Priority: LU over branch over jump
        @(negedge clk); clear_in(); set_load(5'd12); id_rt = 5'd12; id_use_rt = 1'b1;
        id_is_branch = 1'b1; id_is_jump = 1'b1; run_cycle("prio_lu");
        @(negedge clk); clear_in(); id_is_branch = 1'b1; id_is_jump = 1'b1; run_cycle("prio_br");
        @(negedge clk); clear_in(); mem_br_valid = 1'b1; mem_br_taken = 1'b1; run_cycle("prio_resolve");

        // Saturation of the stall counter
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk); clear_in(); set_load(5'd1); id_rs = 5'd1; id_use_rs = 1'b1; run_cycle("sat_stall");
        end
        @(negedge clk); clear_in(); run_cycle("sat_final");

        // Reset pulse in the middle of a branch wait
        @(negedge clk); clear_in(); id_is_branch = 1'b1; run_cycle("rst_issue");
        @(negedge clk); clear_in(); run_cycle("rst_wait0");
        @(negedge clk); clear_in(); mem_br_valid = 1'b1; mem_br_taken = 1'b1;
        clrn = 1'b0;
        #1 check_reset("rst_async");
        model_reset();
        @(negedge clk);
        #1 check_reset("rst_held");
        clrn = 1'b1;
        run_cycle("rst_release_run");
        @(negedge clk); clear_in(); run_cycle("rst_after");

        check_eq("scoreboard_empty", r_sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
